// File: rtl/bt656_encoder.sv
// bt656_encoder: pixel stream to BT.656 words with EAV/SAV codes and fill.
// Progressive only; the input frame locks to output timing on sop/eop.
module bt656_encoder #(
  parameter int DW      = 8,
  parameter int WIDTH   = 1440,
  parameter int HEIGHT  = 480,
  parameter int H_BLANK = 268,
  parameter int V_TOP   = 20,
  parameter int V_BOT   = 25
) (
  input  logic          clk_itu_i,
  input  logic          rst_n,
  input  logic [DW-1:0] din_data,
  input  logic          din_valid,
  input  logic          din_sop,
  input  logic          din_eop,
  output logic          din_ready,
  output logic [DW-1:0] itu_data_o,
  output logic          de_o,
  output logic          locked_o,
  output logic          underflow_o,
  output logic          sync_err_o
);
  localparam int LINE  = 8 + H_BLANK + WIDTH;
  localparam int FRAME = V_TOP + HEIGHT + V_BOT;
  localparam int HW    = $clog2(LINE);
  localparam int VW    = $clog2(FRAME);

  localparam logic [HW-1:0] H_LAST = HW'(LINE - 1);
  localparam logic [HW-1:0] H_SAV  = HW'(4 + H_BLANK);
  localparam logic [HW-1:0] H_ACT  = HW'(8 + H_BLANK);
  localparam logic [VW-1:0] V_LAST = VW'(FRAME - 1);
  localparam logic [VW-1:0] V_A0   = VW'(V_TOP);
  localparam logic [VW-1:0] V_AL   = VW'(V_TOP + HEIGHT - 1);

  function automatic logic [DW-1:0] w8(input logic [7:0] b);
    logic [DW-1:0] w;
    w = '0;
    w[DW-1 -: 8] = b;
    return w;
  endfunction

  localparam logic [DW-1:0] F80 = w8(8'h80);
  localparam logic [DW-1:0] F10 = w8(8'h10);

  logic [HW-1:0] h_q;
  logic [VW-1:0] v_q;
  logic [DW-1:0] data_q, data_d;
  logic          de_q, de_d;
  logic          lock_q, lock_d;
  logic          uf_q, uf_d;
  logic          se_q, se_d;

  logic          act_line, act_slot, slot_on;
  logic          first, last;
  logic          in_eav, in_sav;
  logic          vb, hb, fill_odd;
  logic [1:0]    pos;
  logic [DW-1:0] code, fill;

  assign act_line = (v_q >= V_A0) && (v_q <= V_AL);
  assign act_slot = h_q >= H_ACT;
  assign slot_on  = act_line && act_slot;
  assign first    = slot_on && (v_q == V_A0) && (h_q == H_ACT);
  assign last     = slot_on && (v_q == V_AL) && (h_q == H_LAST);
  assign in_eav   = h_q < HW'(4);
  assign in_sav   = (h_q >= H_SAV) && !act_slot;

  assign vb  = !act_line;
  assign hb  = in_eav;
  assign pos = in_eav ? h_q[1:0] : h_q[1:0] - H_SAV[1:0];

  always_comb begin
    unique case (pos)
      2'd0:       code = '1;
      2'd1, 2'd2: code = '0;
      default:    code = w8({1'b1, 1'b0, vb, hb,
                             vb ^ hb, hb, vb, vb ^ hb});
    endcase
  end

  // Fill phase restarts at the first slot of the blank and active regions.
  assign fill_odd = act_slot ? (h_q[0] ^ H_ACT[0]) : h_q[0];
  assign fill     = fill_odd ? F10 : F80;

  assign din_ready = (lock_q ? slot_on : 1'b1) && (first || !din_sop);

  always_comb begin
    lock_d = lock_q;
    data_d = (in_eav || in_sav) ? code : fill;
    de_d   = 1'b0;
    uf_d   = 1'b0;
    se_d   = 1'b0;
    if (slot_on) begin
      if (!lock_q) begin
        if (first && din_valid && din_sop) begin
          lock_d = 1'b1;
          data_d = din_data;
          de_d   = 1'b1;
        end
      end else if (!din_valid) begin
        uf_d = 1'b1;
      end else if (first ? !din_sop : din_sop) begin
        se_d   = 1'b1;
        lock_d = 1'b0;
      end else begin
        data_d = din_data;
        de_d   = 1'b1;
        if (last != din_eop) begin
          se_d   = 1'b1;
          lock_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_itu_i or negedge rst_n) begin
    if (!rst_n) begin
      h_q    <= '0;
      v_q    <= '0;
      data_q <= F80;
      de_q   <= 1'b0;
      lock_q <= 1'b0;
      uf_q   <= 1'b0;
      se_q   <= 1'b0;
    end else begin
      h_q <= (h_q == H_LAST) ? '0 : h_q + 1'b1;
      if (h_q == H_LAST)
        v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
      data_q <= data_d;
      de_q   <= de_d;
      lock_q <= lock_d;
      uf_q   <= uf_d;
      se_q   <= se_d;
    end
  end

  assign itu_data_o  = data_q;
  assign de_o        = de_q;
  assign locked_o    = lock_q;
  assign underflow_o = uf_q;
  assign sync_err_o  = se_q;
endmodule
